sprite_draw_ctrl: RTL

Control-side initiator for the pixel-drawing datapath. It accepts one draw command (sprite, full screen, or black clear) at a time and rasters the target rectangle row by row. For each pixel it issues a sprite/screen memory address and memory select. After the memory read latency it emits the matching x, y and plot strobe toward the VGA adapter, then pulses done. It sits between the game FSM, which issues commands, and the colour mux plus VGA adapter, which consume its outputs.

---
 rtl/sprite_draw_ctrl_pkg.sv | 32 +++
 rtl/sprite_draw_ctrl_raster_counter.sv | 64 ++++++
 rtl/sprite_draw_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sprite_draw_ctrl_pkg.sv
// Shared types and constants for the sprite/screen draw controller.
package sprite_draw_ctrl_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int SEL_W    = 5;

  // Command encodings on drawMode; 2'b11 behaves like MODE_CLEAR.
  typedef enum logic [1:0] {
    MODE_SPRITE = 2'b00,
    MODE_SCREEN = 2'b01,
    MODE_CLEAR  = 2'b10
  } draw_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One entry of the colour-latency delay line.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           valid;
  } pixel_t;

endpackage

// File: rtl/sprite_draw_ctrl_raster_counter.sv
// Column/row raster counter with a linear pixel address; holds on the last pixel.
module raster_counter
  import sprite_draw_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [X_W-1:0]    width_i,
  input  logic [Y_W-1:0]    height_i,
  output logic [X_W-1:0]    col_o,
  output logic [Y_W-1:0]    row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_end;

  assign col_end = (col_q == width_i - 8'd1);
  assign last_o  = col_end && (row_q == height_i - 7'd1);

  // Next raster position: advance while enabled, never past the last pixel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en_i && !last_o) begin
      addr_d = addr_q + 15'd1;
      if (col_end) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Draw command sequencer: rasters a rectangle, issues memory addresses and
// emits x/y/plot delayed by the colour read latency.
module sprite_draw_ctrl #(
  parameter int ROM_LATENCY = 1,
  parameter int SPRITE_W    = 40,
  parameter int SPRITE_H    = 40,
  parameter int SCREEN_W    = sprite_draw_ctrl_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_draw_ctrl_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        drawReq,
  input  logic [1:0]  drawMode,
  input  logic [4:0]  memorySelIn,
  input  logic [7:0]  xOrigin,
  input  logic [6:0]  yOrigin,
  output logic        busy,
  output logic        drawDone,
  output logic [14:0] memAddr,
  output logic [4:0]  memorySel,
  output logic        black,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot
);

  import sprite_draw_ctrl_pkg::*;

  localparam logic [8:0] CLIP_X     = 9'(SCREEN_W);
  localparam logic [7:0] CLIP_Y     = 8'(SCREEN_H);
  localparam logic [1:0] FLUSH_LAST = 2'(ROM_LATENCY - 1);

  state_e         state_q, state_d;
  logic [1:0]     flush_q, flush_d;
  logic [X_W-1:0] width_q, width_d, x_org_q, x_org_d;
  logic [Y_W-1:0] height_q, height_d, y_org_q, y_org_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic           black_q, black_d;
  logic           accept, scan, sprite_cmd, last_pix;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic [8:0]     sum_x;
  logic [7:0]     sum_y;
  pixel_t         pix_in;
  pixel_t         pipe_q [ROM_LATENCY];

  assign accept     = (state_q == ST_IDLE) && drawReq;
  assign scan       = (state_q == ST_SCAN);
  assign sprite_cmd = (drawMode == MODE_SPRITE);

  // Next state: scan the raster, drain the colour latency, pulse done.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    unique case (state_q)
      ST_IDLE:  if (drawReq) state_d = ST_SCAN;
      ST_SCAN: begin
        if (last_pix) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = ST_DONE;
        else                       flush_d = flush_q + 2'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command capture on acceptance; full-screen modes force the origin to 0.
  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    x_org_d  = x_org_q;
    y_org_d  = y_org_q;
    sel_d    = sel_q;
    black_d  = black_q;
    if (accept) begin
      width_d  = sprite_cmd ? 8'(SPRITE_W) : 8'(SCREEN_W);
      height_d = sprite_cmd ? 7'(SPRITE_H) : 7'(SCREEN_H);
      x_org_d  = sprite_cmd ? xOrigin : '0;
      y_org_d  = sprite_cmd ? yOrigin : '0;
      sel_d    = memorySelIn;
      black_d  = !sprite_cmd && (drawMode != MODE_SCREEN);
    end
  end

  // Control and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      flush_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      x_org_q  <= '0;
      y_org_q  <= '0;
      sel_q    <= '0;
      black_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      width_q  <= width_d;
      height_q <= height_d;
      x_org_q  <= x_org_d;
      y_org_q  <= y_org_d;
      sel_q    <= sel_d;
      black_q  <= black_d;
    end
  end

  raster_counter u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .en_i     (scan),
    .width_i  (width_q),
    .height_i (height_q),
    .col_o    (col),
    .row_o    (row),
    .addr_o   (memAddr),
    .last_o   (last_pix)
  );

  // Screen coordinate of the current pixel; off-screen pixels are not plotted.
  always_comb begin
    sum_x        = {1'b0, x_org_q} + {1'b0, col};
    sum_y        = {1'b0, y_org_q} + {1'b0, row};
    pix_in.x     = sum_x[7:0];
    pix_in.y     = sum_y[6:0];
    pix_in.valid = scan && (sum_x < CLIP_X) && (sum_y < CLIP_Y);
  end

  // Delay line matching the colour read latency.
  always_ff @(posedge clk) begin
    // NOTE: this array is reset because a stale valid bit after reset would plot a pixel.
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pix_in;
      for (int i = 1; i < ROM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy      = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
  assign drawDone  = (state_q == ST_DONE);
  assign memorySel = sel_q;
  assign black     = black_q;
  assign x         = pipe_q[ROM_LATENCY-1].x;
  assign y         = pipe_q[ROM_LATENCY-1].y;
  assign plot      = pipe_q[ROM_LATENCY-1].valid;

endmodule
